// File: rtl/comp_unit_seq_if.sv
// comp_unit_seq_if: sequencer-facing control/data bundle of comp_unit_seq.
// master = program sequencer/decoder side, slave = computational unit.
interface comp_unit_seq_if #(
    parameter int unsigned DATA_W = 4
);
    logic [3:0]        source_sel;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] i_pins;
    logic [DATA_W-1:0] dm;
    logic              i_sel;
    logic              x_sel;
    logic              y_sel;
    logic [8:0]        reg_en;
    logic [DATA_W-1:0] data_bus;
    logic [DATA_W-1:0] o_reg;
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] r_hi;
    logic              r_eq_0;
    logic              carry;
    logic              busy;

    modport master (
        output source_sel, imm, alu_op, i_pins, dm, i_sel, x_sel, y_sel, reg_en,
        input  data_bus, o_reg, i, r, r_hi, r_eq_0, carry, busy
    );

    modport slave (
        input  source_sel, imm, alu_op, i_pins, dm, i_sel, x_sel, y_sel, reg_en,
        output data_bus, o_reg, i, r, r_hi, r_eq_0, carry, busy
    );
endinterface

// File: rtl/comp_unit_seq.sv
// comp_unit_seq: register file, data bus mux, ALU with carry flag and iterative
// shift-add multiplier. Define MULT_ACC_EN to turn op 3 with q=1 into multiply-accumulate.
module comp_unit_seq #(
    parameter int unsigned DATA_W = 4
) (
    input  logic           clk,
    input  logic           sync_reset,
    comp_unit_seq_if.slave cu
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [DATA_W-1:0] m_q, m_d, i_q, i_d, o_reg_q, o_reg_d;
    logic [DATA_W-1:0] r_q, r_d, r_hi_q, r_hi_d;
    logic              r_eq_0_q, r_eq_0_d, carry_q, carry_d, busy_q, busy_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef MULT_ACC_EN
    logic              mac_q, mac_d;
    logic [PROD_W:0]   mac_sum;
`endif

    logic [DATA_W-1:0] bus_c, x_op, y_op;
    logic [DATA_W:0]   alu_wide, step_sum;
    logic [2:0]        op;
    logic              q;
    logic              alu_wr;
    logic              unused_reg_en;

    assign op            = cu.alu_op[2:0];
    assign q             = cu.alu_op[3];
    assign unused_reg_en = cu.reg_en[7];

    // Data bus source mux
    always_comb begin
        bus_c = '0;
        case (cu.source_sel)
            4'd0:    bus_c = x0_q;
            4'd1:    bus_c = x1_q;
            4'd2:    bus_c = y0_q;
            4'd3:    bus_c = y1_q;
            4'd4:    bus_c = r_q;
            4'd5:    bus_c = m_q;
            4'd6:    bus_c = i_q;
            4'd7:    bus_c = cu.dm;
            4'd8:    bus_c = cu.imm;
            4'd9:    bus_c = cu.i_pins;
            4'd10:   bus_c = r_hi_q;
            4'd11:   bus_c = DATA_W'({carry_q, r_eq_0_q});
            default: bus_c = '0;
        endcase
    end

    // Next-state: register file, ALU and multiplier FSM
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        m_d      = m_q;
        i_d      = i_q;
        o_reg_d  = o_reg_q;
        r_d      = r_q;
        r_hi_d   = r_hi_q;
        r_eq_0_d = r_eq_0_q;
        carry_d  = carry_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`ifdef MULT_ACC_EN
        mac_d    = mac_q;
        mac_sum  = '0;
`endif
        alu_wide = '0;
        step_sum = '0;
        alu_wr   = 1'b0;
        x_op     = cu.x_sel ? x1_q : x0_q;
        y_op     = cu.y_sel ? y1_q : y0_q;

        if (cu.reg_en[0]) x0_d = bus_c;
        if (cu.reg_en[1]) x1_d = bus_c;
        if (cu.reg_en[2]) y0_d = bus_c;
        if (cu.reg_en[3]) y1_d = bus_c;
        if (cu.reg_en[5]) m_d  = bus_c;
        if (cu.reg_en[6]) i_d  = cu.i_sel ? (i_q + m_q) : bus_c;
        if (cu.reg_en[8]) o_reg_d = bus_c;

        case (state_q)
            ST_IDLE: begin
                if (cu.reg_en[4]) begin
                    case (op)
                        3'd0: if (!q) begin
                            r_d     = DATA_W'(0) - x_op;
                            carry_d = (x_op != '0);
                            alu_wr  = 1'b1;
                        end
                        3'd1: begin
                            alu_wide = {1'b0, x_op} - {1'b0, y_op};
                            r_d      = alu_wide[DATA_W-1:0];
                            carry_d  = alu_wide[DATA_W];
                            alu_wr   = 1'b1;
                        end
                        3'd2: begin
                            alu_wide = {1'b0, x_op} + {1'b0, y_op};
                            r_d      = alu_wide[DATA_W-1:0];
                            carry_d  = alu_wide[DATA_W];
                            alu_wr   = 1'b1;
                        end
                        3'd3: begin
                            state_d = ST_RUN;
                            mcand_d = x_op;
                            prod_d  = {DATA_W'(0), y_op};
                            cnt_d   = CNT_W'(DATA_W);
`ifdef MULT_ACC_EN
                            mac_d   = q;
`endif
                        end
                        3'd4: begin
                            r_d     = x_op << 1;
                            carry_d = x_op[DATA_W-1];
                            alu_wr  = 1'b1;
                        end
                        3'd5: begin
                            r_d     = x_op ^ y_op;
                            carry_d = 1'b0;
                            alu_wr  = 1'b1;
                        end
                        3'd6: begin
                            r_d     = x_op & y_op;
                            carry_d = 1'b0;
                            alu_wr  = 1'b1;
                        end
                        3'd7: if (!q) begin
                            r_d     = ~x_op;
                            carry_d = 1'b0;
                            alu_wr  = 1'b1;
                        end
                    endcase
                    if (alu_wr) r_eq_0_d = (r_d == '0);
                end
            end
            ST_RUN: begin
                // prod_q holds {acc_hi, remaining multiplier bits}; shift right with the add carry
                step_sum = {1'b0, prod_q[PROD_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
                prod_d   = {step_sum, prod_q[DATA_W-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                {r_hi_d, r_d} = prod_q;
                carry_d       = 1'b0;
                r_eq_0_d      = (prod_q == '0);
`ifdef MULT_ACC_EN
                if (mac_q) begin
                    mac_sum       = {1'b0, r_hi_q, r_q} + {1'b0, prod_q};
                    {r_hi_d, r_d} = mac_sum[PROD_W-1:0];
                    carry_d       = mac_sum[PROD_W];
                    r_eq_0_d      = (mac_sum[PROD_W-1:0] == '0);
                end
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            m_q      <= '0;
            i_q      <= '0;
            o_reg_q  <= '0;
            r_q      <= '0;
            r_hi_q   <= '0;
            r_eq_0_q <= 1'b1;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
`ifdef MULT_ACC_EN
            mac_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            m_q      <= m_d;
            i_q      <= i_d;
            o_reg_q  <= o_reg_d;
            r_q      <= r_d;
            r_hi_q   <= r_hi_d;
            r_eq_0_q <= r_eq_0_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`ifdef MULT_ACC_EN
            mac_q    <= mac_d;
`endif
        end
    end

    assign cu.data_bus = bus_c;
    assign cu.o_reg    = o_reg_q;
    assign cu.i        = i_q;
    assign cu.r        = r_q;
    assign cu.r_hi     = r_hi_q;
    assign cu.r_eq_0   = r_eq_0_q;
    assign cu.carry    = carry_q;
    assign cu.busy     = busy_q;
endmodule

// File: doc/comp_unit_seq.md
Name: comp_unit_seq

Overview:
Parametrised successor to the 4-bit computational unit. Width is set by DATA_W, and the block provides the same register file and data bus mux. It adds a carry flag, a full-width product register pair {r_hi, r}, and an iterative shift-add multiplier with a busy handshake. It sits between the program sequencer/decoder (which drives selects, enables and alu_op) and data memory/pins.

Parameters:
DATA_W, 4, width of every data register, the data bus and each ALU operand.

Ports:
clk  in  1  system clock, all state updates on rising edge
sync_reset  in  1  synchronous active-high reset
source_sel  in  4  data_bus source select
imm  in  DATA_W  immediate operand from the instruction (pm_data)
alu_op  in  4  [2:0] ALU function, [3] qualifier
i_pins  in  DATA_W  external input pins
dm  in  DATA_W  data memory read data
i_sel  in  1  0: i loads data_bus; 1: i <= i + m
x_sel  in  1  ALU x operand: 0 = x0, 1 = x1
y_sel  in  1  ALU y operand: 0 = y0, 1 = y1
reg_en  in  9  write enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]r/ALU [5]m [6]i [7]unused [8]o_reg
data_bus  out  DATA_W  internal bus, combinational
o_reg  out  DATA_W  output register
i  out  DATA_W  index register
r  out  DATA_W  ALU result / product low half
r_hi  out  DATA_W  product high half
r_eq_0  out  1  zero flag
carry  out  1  carry/borrow flag
busy  out  1  multiplier running

Behaviour:
- Reset values: x0, x1, y0, y1, m, i, o_reg, r and r_hi = 0; r_eq_0 = 1; carry = 0; busy = 0; FSM = IDLE.
- Registers load data_bus on the edge where their reg_en bit is 1; otherwise they hold.
- When i_sel = 1, i <= (i + m) mod 2^DATA_W.
- data_bus by source_sel:
  - 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 imm, 9 i_pins.
  - 10 r_hi.
  - 11 = {zero-extended, carry, r_eq_0}.
  - 12–15 = 0.
- Single-cycle ops (reg_en[4] = 1, busy = 0) write r and the flags on the same edge. r_hi is unchanged. r_eq_0 = (new r == 0).
  - 0, q = 0: r = -x; carry = (x != 0).
  - 1: r = x - y; carry = borrow (x < y, unsigned).
  - 2: r = x + y; carry = carry-out.
  - 4: r = x << 1; carry = x[MSB].
  - 5: r = x ^ y; carry = 0.
  - 6: r = x & y; carry = 0.
  - 7, q = 0: r = ~x; carry = 0.
  - 0 or 7 with q = 1: no-op. r, r_hi and flags hold.
- Multiply (op 3) uses a three-state FSM: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge with reg_en[4] = 1, op = 3 and busy = 0. On that edge the FSM latches mcand = x and mplier = y, clears the 2*DATA_W accumulator, and sets cnt = DATA_W.
  - RUN, each cycle: if mplier[0], acc_hi += mcand. Then shift {carry_int, acc, mplier} right by 1 and decrement cnt. When cnt reaches 1 the FSM goes to DONE.
  - DONE, one cycle: {r_hi, r} <= product; r_eq_0 = (product == 0, full width); carry = 0; then -> IDLE.
  - busy = 1 in RUN and DONE, i.e. for DATA_W+1 cycles after the start edge. r and r_hi update on the edge at which busy falls.
- While busy: reg_en[4] is ignored (no write, no new start, flags hold). All other registers write normally. The latched operands make the result immune to x/y changes. data_bus source 4 or 10 returns the old values.
- sync_reset has priority over everything, including mid-multiply: the FSM goes to IDLE, busy = 0 on the next cycle, and every reset value applies. No partial product is written.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined: op 3 with q = 1 is multiply-accumulate. It uses the same FSM and latency. In DONE, {r_hi, r} <= ({r_hi, r} + x*y) mod 2^(2*DATA_W), and carry = carry-out of the 2*DATA_W addition. r_eq_0 reflects the full 2*DATA_W result.
- Undefined: op 3 ignores q and always performs a plain multiply.

Test Plan:
- Reset: hold sync_reset one cycle after arbitrary writes -> all registers 0, r_eq_0 = 1, carry = 0, busy = 0.
- Add/sub flags (DATA_W = 4):
  - x0 = 9, y0 = 8, op 2 -> r = 1, carry = 1, r_eq_0 = 0.
  - Then x0 = 3, y0 = 3, op 1 -> r = 0, carry = 0, r_eq_0 = 1.
  - Then x0 = 2, y0 = 5, op 1 -> r = D, carry = 1.
- Multiply: x1 = F, y1 = F, x_sel = y_sel = 1, op 3 -> busy high 5 cycles, then r_hi = E, r = 1, r_eq_0 = 0. A reg_en[4] op 2 pulse and an x1 write during busy must not change the result.
- Reset mid-multiply: assert sync_reset on the third busy cycle -> busy = 0, r = 0, r_hi = 0, r_eq_0 = 1 on the next cycle; a new multiply afterwards completes correctly.
- Index and bus:
  - m = 7, i = C, reg_en[6] with i_sel = 1 -> i = 3.
  - source_sel = 11 with carry = 1, r_eq_0 = 0 -> data_bus = 2; source_sel = 13 -> data_bus = 0.
- MULT_ACC_EN:
  - {r_hi, r} = E1, x = 1, y = F, op 3 with q = 1 -> F0, carry = 0.
  - Then {r_hi, r} = FF, x = 1, y = 1 -> 00, carry = 1, r_eq_0 = 1.
